// File: rtl/sc_player_lane_controller.sv
// Purpose: road-game player controller; one-hot lane, hold-to-repeat moves, lives, respawn, game over.
// Latency: every output is registered, so an input sampled at edge N shows after edge N.
// Backpressure: none; buttons, crash and level-done are level inputs evaluated every cycle.
module sc_player_lane_controller #(
    parameter int LANES          = 8,
    parameter int START_LANE     = 1,
    parameter int LIVES          = 3,
    parameter int REPEAT_CYCLES  = 12500000,
    parameter int RESPAWN_CYCLES = 50000000
) (
    input  logic                     SC_PLAYER_LANE_CLOCK_50,
    input  logic                     SC_PLAYER_LANE_RESET_InLow,
    input  logic                     SC_PLAYER_LANE_LeftButton_InLow,
    input  logic                     SC_PLAYER_LANE_RightButton_InLow,
    input  logic                     SC_PLAYER_LANE_Crash_InLow,
    input  logic                     SC_PLAYER_LANE_LevelDone_InLow,
    output logic [LANES-1:0]         SC_PLAYER_LANE_Position_Out,
    output logic [$clog2(LANES)-1:0] SC_PLAYER_LANE_Lane_Out,
    output logic [3:0]               SC_PLAYER_LANE_Lives_Out,
    output logic                     SC_PLAYER_LANE_Alive_Out,
    output logic                     SC_PLAYER_LANE_GameOver_Out
);
    localparam int LW = $clog2(LANES);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam int DW = $clog2(RESPAWN_CYCLES + 1);
    localparam logic [LW-1:0] LAST_LANE  = LW'(LANES - 1);
    localparam logic [LW-1:0] FIRST_LANE = LW'(START_LANE);
    localparam logic [3:0]    FULL_LIVES = 4'(LIVES);
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_CYCLES - 1);
    localparam logic [DW-1:0] RESP_LAST  = DW'(RESPAWN_CYCLES - 1);
    localparam logic [LANES-1:0] ONE     = {{(LANES-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        LOAD     = 3'd0,
        STILL    = 3'd1,
        HOLD     = 3'd2,
        DEAD     = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    state_t        state, next_state;
    logic [LW-1:0] lane, next_lane;
    logic [3:0]    lives, next_lives;
    logic          alive, next_alive;
    logic          gameover, next_gameover;
    logic          dir_left, next_dir_left;
    logic [RW-1:0] rep_cnt, next_rep_cnt;
    logic [DW-1:0] resp_cnt, next_resp_cnt;
    logic [LANES-1:0] position, next_position;

    logic left, right, crash, done;
    logic go_load, crash_hit;
    logic [LW-1:0] lane_up, lane_dn;

    assign left    = ~SC_PLAYER_LANE_LeftButton_InLow;
    assign right   = ~SC_PLAYER_LANE_RightButton_InLow;
    assign crash   = ~SC_PLAYER_LANE_Crash_InLow;
    assign done    = ~SC_PLAYER_LANE_LevelDone_InLow;
    assign lane_up = (lane == LAST_LANE) ? lane : lane + LW'(1);
    assign lane_dn = (lane == '0) ? lane : lane - LW'(1);

    always_ff @(posedge SC_PLAYER_LANE_CLOCK_50 or negedge SC_PLAYER_LANE_RESET_InLow) begin
        if (!SC_PLAYER_LANE_RESET_InLow) begin
            state    <= LOAD;
            lane     <= FIRST_LANE;
            lives    <= FULL_LIVES;
            alive    <= 1'b1;
            gameover <= 1'b0;
            dir_left <= 1'b0;
            rep_cnt  <= '0;
            resp_cnt <= '0;
            position <= ONE << FIRST_LANE;
        end else begin
            state    <= next_state;
            lane     <= next_lane;
            lives    <= next_lives;
            alive    <= next_alive;
            gameover <= next_gameover;
            dir_left <= next_dir_left;
            rep_cnt  <= next_rep_cnt;
            resp_cnt <= next_resp_cnt;
            position <= next_position;
        end
    end

    always_comb begin
        next_state    = state;
        next_lane     = lane;
        next_lives    = lives;
        next_alive    = alive;
        next_gameover = gameover;
        next_dir_left = dir_left;
        next_rep_cnt  = rep_cnt;
        next_resp_cnt = resp_cnt;
        go_load       = 1'b0;
        crash_hit     = 1'b0;

        case (state)
            LOAD: begin
                next_lane     = FIRST_LANE;
                next_rep_cnt  = '0;
                next_alive    = 1'b1;
                next_gameover = 1'b0;
                next_state    = STILL;
            end
            STILL: begin
                if (crash) begin
                    crash_hit = 1'b1;
                end else if (done) begin
                    go_load = 1'b1;
                end else if (left && !right) begin
                    next_lane     = lane_up;
                    next_dir_left = 1'b1;
                    next_rep_cnt  = '0;
                    next_state    = HOLD;
                end else if (right && !left) begin
                    next_lane     = lane_dn;
                    next_dir_left = 1'b0;
                    next_rep_cnt  = '0;
                    next_state    = HOLD;
                end
            end
            HOLD: begin
                if (crash) begin
                    crash_hit = 1'b1;
                end else if (done) begin
                    go_load = 1'b1;
                end else if ((left && right) || (dir_left ? !left : !right)) begin
                    // Opposite button alone lands here too; STILL then moves the other way.
                    next_rep_cnt = '0;
                    next_state   = STILL;
                end else if (rep_cnt == REP_LAST) begin
                    next_lane    = dir_left ? lane_up : lane_dn;
                    next_rep_cnt = '0;
                end else begin
                    next_rep_cnt = rep_cnt + RW'(1);
                end
            end
            DEAD: begin
                if (resp_cnt == RESP_LAST) begin
                    go_load = 1'b1;
                end else begin
                    next_resp_cnt = resp_cnt + DW'(1);
                end
            end
            GAMEOVER: begin
                if (done) begin
                    next_lives = FULL_LIVES;
                    go_load    = 1'b1;
                end
            end
            default: go_load = 1'b1;
        endcase

        if (crash_hit) begin
            next_lives    = (lives == 4'd0) ? 4'd0 : lives - 4'd1;
            next_alive    = 1'b0;
            next_rep_cnt  = '0;
            next_resp_cnt = '0;
            if (next_lives == 4'd0) begin
                next_state    = GAMEOVER;
                next_gameover = 1'b1;
            end else begin
                next_state = DEAD;
            end
        end

        if (go_load) begin
            next_state    = LOAD;
            next_lane     = FIRST_LANE;
            next_alive    = 1'b1;
            next_gameover = 1'b0;
            next_rep_cnt  = '0;
            next_resp_cnt = '0;
        end

        next_position = next_alive ? (ONE << next_lane) : '0;
    end

    assign SC_PLAYER_LANE_Position_Out = position;
    assign SC_PLAYER_LANE_Lane_Out     = lane;
    assign SC_PLAYER_LANE_Lives_Out    = lives;
    assign SC_PLAYER_LANE_Alive_Out    = alive;
    assign SC_PLAYER_LANE_GameOver_Out = gameover;
endmodule

// File: tb/tb_sc_player_lane_controller.sv
// Directed bench for sc_player_lane_controller with LANES=8, START_LANE=3, LIVES=2, REPEAT=4, RESPAWN=3.
module tb_sc_player_lane_controller;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       left_n, right_n, crash_n, done_n;
    logic [7:0] position;
    logic [2:0] lane;
    logic [3:0] lives;
    logic       alive, gameover;

    int checks = 0;
    int errors = 0;

    sc_player_lane_controller #(
        .LANES(8), .START_LANE(3), .LIVES(2), .REPEAT_CYCLES(4), .RESPAWN_CYCLES(3)
    ) dut (
        .SC_PLAYER_LANE_CLOCK_50         (clk),
        .SC_PLAYER_LANE_RESET_InLow      (rst_n),
        .SC_PLAYER_LANE_LeftButton_InLow (left_n),
        .SC_PLAYER_LANE_RightButton_InLow(right_n),
        .SC_PLAYER_LANE_Crash_InLow      (crash_n),
        .SC_PLAYER_LANE_LevelDone_InLow  (done_n),
        .SC_PLAYER_LANE_Position_Out     (position),
        .SC_PLAYER_LANE_Lane_Out         (lane),
        .SC_PLAYER_LANE_Lives_Out        (lives),
        .SC_PLAYER_LANE_Alive_Out        (alive),
        .SC_PLAYER_LANE_GameOver_Out     (gameover)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; left_n = 1'b1; right_n = 1'b1; crash_n = 1'b1; done_n = 1'b1;
        #12;
        chk("rst_lane", 32'(lane), 32'd3);
        chk("rst_pos", 32'(position), 32'h08);
        rst_n = 1'b1;
        tick(2);
        chk("idle_lane", 32'(lane), 32'd3);
        chk("idle_pos", 32'(position), 32'h08);
        chk("idle_lives", 32'(lives), 32'd2);
        chk("idle_alive", 32'(alive), 32'd1);
        chk("idle_go", 32'(gameover), 32'd0);

        // Hold left: 4 on first edge, then +1 every 4 edges, saturating at 7.
        left_n = 1'b0;
        tick(1);
        chk("hold_e0", 32'(lane), 32'd4);
        for (int i = 1; i < 14; i++) begin
            tick(1);
            chk($sformatf("hold_e%0d", i), 32'(lane), (4 + i / 4 > 7) ? 32'd7 : 32'(4 + i / 4));
        end
        chk("hold_pos", 32'(position), 32'h80);
        left_n = 1'b1;
        tick(2);
        chk("release_lane", 32'(lane), 32'd7);

        left_n = 1'b0; right_n = 1'b0;
        tick(2);
        chk("both_lane", 32'(lane), 32'd7);
        left_n = 1'b1; right_n = 1'b1;
        tick(1);
        right_n = 1'b0;
        tick(1);
        chk("tap_r_lane", 32'(lane), 32'd6);
        right_n = 1'b1;
        tick(2);
        chk("tap_r_once", 32'(lane), 32'd6);
        chk("tap_r_pos", 32'(position), 32'h40);
        right_n = 1'b0;
        tick(1);
        right_n = 1'b1;
        tick(1);
        chk("lane5", 32'(lane), 32'd5);

        crash_n = 1'b0;
        tick(1);
        crash_n = 1'b1;
        chk("crash1_lives", 32'(lives), 32'd1);
        chk("crash1_alive", 32'(alive), 32'd0);
        chk("crash1_pos", 32'(position), 32'h00);
        left_n = 1'b0;
        tick(2);
        chk("dead_alive", 32'(alive), 32'd0);
        chk("dead_pos", 32'(position), 32'h00);
        left_n = 1'b1;
        tick(2);
        chk("respawn_lane", 32'(lane), 32'd3);
        chk("respawn_alive", 32'(alive), 32'd1);
        chk("respawn_pos", 32'(position), 32'h08);
        chk("respawn_lives", 32'(lives), 32'd1);

        crash_n = 1'b0;
        tick(1);
        crash_n = 1'b1;
        chk("crash2_lives", 32'(lives), 32'd0);
        chk("crash2_go", 32'(gameover), 32'd1);
        chk("crash2_alive", 32'(alive), 32'd0);
        left_n = 1'b0;
        tick(2);
        chk("go_pos", 32'(position), 32'h00);
        chk("go_lane", 32'(lane), 32'd3);
        left_n = 1'b1;
        crash_n = 1'b0;
        tick(1);
        crash_n = 1'b1;
        chk("go_no_underflow", 32'(lives), 32'd0);
        done_n = 1'b0;
        tick(1);
        done_n = 1'b1;
        chk("restart_lives", 32'(lives), 32'd2);
        chk("restart_lane", 32'(lane), 32'd3);
        chk("restart_go", 32'(gameover), 32'd0);
        tick(1);
        chk("restart_alive", 32'(alive), 32'd1);

        // Reach lane 6 while holding, then reset mid-timer.
        left_n = 1'b0;
        tick(9);
        chk("pre_rst_lane", 32'(lane), 32'd6);
        tick(2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_lane", 32'(lane), 32'd3);
        chk("async_pos", 32'(position), 32'h08);
        chk("async_lives", 32'(lives), 32'd2);
        chk("async_alive", 32'(alive), 32'd1);
        chk("async_go", 32'(gameover), 32'd0);
        left_n = 1'b1;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_lane", 32'(lane), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
